// File: rtl/seq_accum_alu.sv
// Accumulator ALU: operand A from Data, operand B from the low half of the accumulator.
// Single-cycle ops complete at the accept edge; multiply runs one multiplier bit per cycle.
module seq_accum_alu #(
   parameter int WIDTH = 4
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Go,
   input  logic [WIDTH-1:0]     Data,
   input  logic [2:0]           Function,
   output logic [2*WIDTH-1:0]   ALUout,
   output logic                 Busy,
   output logic                 Done,
   output logic                 Carry,
   output logic                 Zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, MUL} state_t;

   state_t               state_reg, state_next;
   logic [2*WIDTH-1:0]   alu_reg, alu_next;
   logic                 carry_reg, carry_next;
   logic                 done_reg, done_next;
   logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
   logic [WIDTH-1:0]     mplier_reg, mplier_next;
   logic [2*WIDTH-1:0]   prod_reg, prod_next;
   logic [CW-1:0]        count_reg, count_next;

   logic [WIDTH-1:0]     b;
   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       diff;
   logic [2*WIDTH-1:0]   partial;

   assign b       = alu_reg[WIDTH-1:0];
   assign sum     = {1'b0, Data} + {1'b0, b};
   assign diff    = {1'b0, Data} - {1'b0, b};
   assign partial = prod_reg + (mplier_reg[0] ? mcand_reg : '0);

   always_comb begin
      state_next  = state_reg;
      alu_next    = alu_reg;
      carry_next  = carry_reg;
      done_next   = 1'b0;
      mcand_next  = mcand_reg;
      mplier_next = mplier_reg;
      prod_next   = prod_reg;
      count_next  = count_reg;
      case (state_reg)
         IDLE: begin
            if (Go) begin
               case (Function)
                  3'b000: begin
                     alu_next   = {{(WIDTH-1){1'b0}}, sum};
                     carry_next = sum[WIDTH];
                     done_next  = 1'b1;
                  end
                  3'b001: begin
                     // Bit WIDTH of the widened difference is the borrow out.
                     alu_next   = {{WIDTH{diff[WIDTH-1]}}, diff[WIDTH-1:0]};
                     carry_next = diff[WIDTH];
                     done_next  = 1'b1;
                  end
                  3'b010: begin
                     alu_next  = {{WIDTH{b[WIDTH-1]}}, b};
                     done_next = 1'b1;
                  end
                  3'b011: begin
                     alu_next  = {{(2*WIDTH-1){1'b0}}, |{Data, b}};
                     done_next = 1'b1;
                  end
                  3'b100: begin
                     alu_next  = {{(2*WIDTH-1){1'b0}}, &{Data, b}};
                     done_next = 1'b1;
                  end
                  3'b101: begin
                     alu_next  = {Data, b};
                     done_next = 1'b1;
                  end
                  3'b110: begin
                     mcand_next  = {{WIDTH{1'b0}}, Data};
                     mplier_next = b;
                     prod_next   = '0;
                     count_next  = '0;
                     state_next  = MUL;
                  end
                  default: ;
               endcase
            end
         end
         MUL: begin
            prod_next   = partial;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            count_next  = count_reg + CW'(1);
            if (count_reg == CW'(WIDTH-1)) begin
               alu_next   = partial;
               carry_next = 1'b0;
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_reg  <= IDLE;
         alu_reg    <= '0;
         carry_reg  <= 1'b0;
         done_reg   <= 1'b0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         prod_reg   <= '0;
         count_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         alu_reg    <= alu_next;
         carry_reg  <= carry_next;
         done_reg   <= done_next;
         mcand_reg  <= mcand_next;
         mplier_reg <= mplier_next;
         prod_reg   <= prod_next;
         count_reg  <= count_next;
      end
   end

   assign ALUout = alu_reg;
   assign Carry  = carry_reg;
   assign Done   = done_reg;
   assign Busy   = (state_reg == MUL);
   assign Zero   = (alu_reg == '0);

endmodule
